// File: rtl/trigger_pkg.sv
// Shared encodings for the trigger gate: detection modes, FSM states and a busy decode.
package trigger_pkg;

    typedef enum logic [1:0] {
        TRIG_OR_LVL  = 2'b00,
        TRIG_OR_EDGE = 2'b01,
        TRIG_AND_LVL = 2'b10,
        TRIG_SINGLE  = 2'b11
    } trig_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_FIRE    = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_DONE    = 3'd4
    } trig_state_e;

    function automatic logic state_is_busy(input trig_state_e st);
        return (st == ST_FIRE) || (st == ST_HOLDOFF) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/trigger_hit_detect.sv
// Masks and registers the trigger vector, then reduces it to a hit per the selected mode.
// One register stage from input to hit; no backpressure, samples every cycle.
module trigger_hit_detect
    import trigger_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] trigger_vector_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic [1:0]        mode_i,
    output logic              hit_o,
    output logic [NUM_CH-1:0] vec_o
);

    logic [NUM_CH-1:0] vec_q, vec_d;
    logic [NUM_CH-1:0] vec_qq;
    logic [NUM_CH-1:0] rise;
    logic              hit_raw;

    assign vec_d = trigger_vector_i & ch_mask_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            vec_qq <= '0;
        end else begin
            vec_q  <= vec_d;
            vec_qq <= vec_q;
        end
    end

    assign rise = vec_q & ~vec_qq;

    always_comb begin
        hit_raw = 1'b0;
        case (trig_mode_e'(mode_i))
            TRIG_OR_LVL:               hit_raw = |vec_q;
            TRIG_OR_EDGE, TRIG_SINGLE: hit_raw = |rise;
            TRIG_AND_LVL:              hit_raw = (vec_q == ch_mask_i);
            default:                   hit_raw = 1'b0;
        endcase
    end

    // vec_q may still hold bits from a previous mask; an empty mask must never fire
    assign hit_o = hit_raw && (|ch_mask_i);
    assign vec_o = vec_q;

endmodule

// File: rtl/trigger_gate.sv
// Qualified trigger FSM: arm, fire, holdoff, single-shot done; fire pulse, channels and count.
// Input edge N -> trigger_start after edge N+1; trigger_ready=0 blocks firing, hits are dropped.
module trigger_gate
    import trigger_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int HOLDOFF_W = 16,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 capture_en,
    input  logic                 trigger_ready,
    input  logic [NUM_CH-1:0]    trigger_vector,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic [1:0]           mode,
    input  logic [HOLDOFF_W-1:0] holdoff_cycles,
    output logic                 trigger_start,
    output logic [NUM_CH-1:0]    trigger_ch,
    output logic [CNT_W-1:0]     trigger_count,
    output logic                 busy
);

    trig_state_e          state_q, state_d;
    logic [HOLDOFF_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_CH-1:0]    ch_q, ch_d;

    logic              hit;
    logic [NUM_CH-1:0] vec_q;
    logic              fire;

    trigger_hit_detect #(
        .NUM_CH (NUM_CH)
    ) u_hit (
        .clk              (clk),
        .rst_n            (rst_n),
        .trigger_vector_i (trigger_vector),
        .ch_mask_i        (ch_mask),
        .mode_i           (mode),
        .hit_o            (hit),
        .vec_o            (vec_q)
    );

    assign fire = hit && trigger_ready && capture_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            count_q    <= '0;
            ch_q       <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            count_q    <= count_d;
            ch_q       <= ch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        count_d    = count_q;
        ch_d       = ch_q;

        if (!capture_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                    count_d = '0;
                end
                ST_ARMED: begin
                    if (fire) begin
                        state_d = ST_FIRE;
                        count_d = count_q + CNT_W'(1);
                        ch_d    = vec_q;
                    end
                end
                ST_FIRE: begin
                    if (trig_mode_e'(mode) == TRIG_SINGLE) begin
                        state_d = ST_DONE;
                    end else if (holdoff_cycles != '0) begin
                        // counter ends at zero so HOLDOFF lasts exactly holdoff_cycles cycles
                        state_d    = ST_HOLDOFF;
                        hold_cnt_d = holdoff_cycles - HOLDOFF_W'(1);
                    end else if (fire) begin
                        state_d = ST_FIRE;
                        count_d = count_q + CNT_W'(1);
                        ch_d    = vec_q;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign trigger_start = (state_q == ST_FIRE);
    assign busy          = state_is_busy(state_q);
    assign trigger_ch    = ch_q;
    assign trigger_count = count_q;

endmodule
